// File: rtl/bus_invert_rx.sv
// bus_invert_rx: receive side of the segmented bus-invert link.
// Decodes {X, INV} words into S, buffers them in a 2-entry FIFO and keeps
// word/error statistics. Optional protocol checker is compiled in when the
// macro PROTOCOL_CHECK_EN is defined; without it err_cnt, seg_err and
// err_pulse are tied to zero.
module bus_invert_rx #(
  parameter int M = 5,
  parameter int k = 32,
  parameter int A = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [k+M-1:0] bus_in,
  input  logic           bus_valid,
  output logic           bus_ready,
  output logic [k-1:0]   s_out,
  output logic           s_valid,
  input  logic           s_ready,
  input  logic           clr_stats,
  output logic [15:0]    word_cnt,
  output logic [15:0]    err_cnt,
  output logic [M-1:0]   seg_err,
  output logic           err_pulse
);

  // Segments 0..R-1 are WA bits wide, the remaining ones WB bits wide.
  localparam int unsigned R  = (k + M) % M;
  localparam int unsigned WA = A - 1;
  localparam int unsigned WB = A - 2;

  // Queue occupancy encodings.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  function automatic int unsigned seg_width(input int unsigned i);
    return (i < R) ? WA : WB;
  endfunction

  function automatic int unsigned seg_lo(input int unsigned i);
    int unsigned lo;
    lo = 0;
    for (int unsigned n = 0; n < i; n++) begin
      lo = lo + seg_width(n);
    end
    return lo;
  endfunction

  // Bit mask covering segment i of a k-bit word (segment 0 at the LSBs).
  function automatic logic [k-1:0] seg_mask(input int unsigned i);
    logic [k-1:0] m;
    int unsigned  lo;
    int unsigned  hi;
    m  = '0;
    lo = seg_lo(i);
    hi = lo + seg_width(i);
    for (int unsigned b = 0; b < k; b++) begin
      if (b >= lo && b < hi) m[b] = 1'b1;
    end
    return m;
  endfunction

  logic [k-1:0] x_in;
  logic [M-1:0] inv_in;
  logic [k-1:0] inv_bits;
  logic [k-1:0] dec;
  logic         accept;
  logic         pop;

  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic [k-1:0] tail;
  logic [k-1:0] head_nxt;
  logic [k-1:0] tail_nxt;

  logic [k-1:0] x_prev;
  logic [M-1:0] inv_prev;

  assign x_in      = bus_in[k+M-1:M];
  assign inv_in    = bus_in[M-1:0];
  assign bus_ready = en & (count < FULL);
  assign accept    = en & bus_valid & bus_ready;
  assign pop       = en & s_valid & s_ready;

  // Expand the per-segment INV flags to a per-bit inversion mask and decode.
  always_comb begin
    inv_bits = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (inv_in[i]) inv_bits = inv_bits | seg_mask(i);
    end
    dec = x_in ^ inv_bits;
  end

  // Next queue contents; s_out is the head register itself.
  always_comb begin
    count_nxt = count;
    head_nxt  = s_out;
    tail_nxt  = tail;
    case (count)
      EMPTY: begin
        if (accept) begin
          head_nxt  = dec;
          count_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_nxt = dec;
        end else if (accept) begin
          tail_nxt  = dec;
          count_nxt = FULL;
        end else if (pop) begin
          count_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_nxt  = tail;
          count_nxt = ONE;
        end
      end
      default: count_nxt = EMPTY;
    endcase
  end

  // Queue registers; s_valid tracks the next occupancy so it is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= EMPTY;
      s_out   <= '0;
      tail    <= '0;
      s_valid <= 1'b0;
    end else begin
      count   <= count_nxt;
      s_out   <= head_nxt;
      tail    <= tail_nxt;
      s_valid <= (count_nxt != EMPTY);
    end
  end

  // Last accepted encoded word, the reference for the inversion decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev   <= '0;
      inv_prev <= '0;
    end else if (accept) begin
      x_prev   <= x_in;
      inv_prev <= inv_in;
    end
  end

  // Accepted-word counter, saturating; clr_stats wins over an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (en) begin
      if (clr_stats)                        word_cnt <= '0;
      else if (accept && word_cnt != '1)    word_cnt <= word_cnt + 16'd1;
    end
  end

`ifdef PROTOCOL_CHECK_EN
  localparam int unsigned CW = $clog2(A) + 1;

  logic [k-1:0]  diff;
  logic [k-1:0]  masked;
  logic [CW-1:0] seg_sum [M];
  logic [CW-1:0] half;
  logic          exp_inv;
  logic [M-1:0]  viol;

  // Re-derive the transmitter's per-segment decision and flag disagreement.
  always_comb begin
    diff    = dec ^ x_prev;
    masked  = '0;
    half    = '0;
    exp_inv = 1'b0;
    viol    = '0;
    for (int unsigned i = 0; i < M; i++) begin
      seg_sum[i] = '0;
      masked     = diff & seg_mask(i);
      for (int unsigned b = 0; b < k; b++) begin
        seg_sum[i] = seg_sum[i] + CW'(masked[b]);
      end
      half    = CW'(seg_width(i) / 2);
      exp_inv = (seg_sum[i] > half) | ((seg_sum[i] == half) & inv_prev[i]);
      viol[i] = (inv_in[i] != exp_inv);
    end
  end

  // Error statistics; err_pulse marks the edge that registered a bad word.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt   <= '0;
      seg_err   <= '0;
      err_pulse <= 1'b0;
    end else if (en) begin
      err_pulse <= accept & (|viol);
      if (clr_stats) begin
        err_cnt <= '0;
        seg_err <= '0;
      end else if (accept) begin
        if ((|viol) && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        seg_err <= seg_err | viol;
      end
    end
  end
`else
  // Checker not built; history registers are kept for drop-in equivalence.
  logic unused_prev;
  assign unused_prev = ^{x_prev, inv_prev};
  assign err_cnt     = '0;
  assign seg_err     = '0;
  assign err_pulse   = 1'b0;
`endif

endmodule
